// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the E stage; owns the architectural HI/LO registers.
// The result is computed at acceptance and parked until the busy window expires.
module mdu_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MultCnt = 4'(MULT_CYCLES);
  localparam logic [3:0] DivCnt  = 4'(DIV_CYCLES);

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMthi  = 3'b100;
  localparam logic [2:0] OpMtlo  = 3'b101;

  typedef enum logic {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  // Datapath: both results are evaluated from the live operands; only the
  // acceptance edge captures them.
  logic        is_signed;
  logic [63:0] a_ext, b_ext, product;
  logic        a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, b_safe;
  logic [31:0] q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = ~mdop[0];
    a_ext     = is_signed ? {{32{A[31]}}, A} : {32'b0, A};
    b_ext     = is_signed ? {{32{B[31]}}, B} : {32'b0, B};
    product   = a_ext * b_ext;
  end

  always_comb begin
    a_neg    = is_signed & A[31];
    b_neg    = is_signed & B[31];
    a_mag    = a_neg ? (32'd0 - A) : A;
    b_mag    = b_neg ? (32'd0 - B) : B;
    div_zero = (B == 32'd0);
    // Keeps the divider well-defined; the result is dropped anyway on B == 0.
    b_safe   = div_zero ? 32'd1 : b_mag;
    q_mag    = a_mag / b_safe;
    r_mag    = a_mag % b_safe;
    // Quotient truncates toward zero; remainder follows the dividend's sign.
    // 0x80000000 / -1 falls out as 0x80000000 rem 0 from the magnitude path.
    quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem      = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          case (mdop)
            OpMult, OpMultu: begin
              pend_hi_d = product[63:32];
              pend_lo_d = product[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = MultCnt;
              state_d   = StBusy;
            end
            OpDiv, OpDivu: begin
              pend_hi_d = rem;
              pend_lo_d = quot;
              pend_wr_d = ~div_zero;
              cnt_d     = DivCnt;
              state_d   = StBusy;
            end
            OpMthi:  hi_d = A;
            OpMtlo:  lo_d = A;
            default: ;
          endcase
        end
      end
      StBusy: begin
        // Starts arriving here are ignored outright, including mthi/mtlo.
        if (cnt_q <= 4'd1) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_wr_d = 1'b0;
          cnt_d     = 4'd0;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
